// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
// Multi-cycle MIPS32 subset core (FETCH/DECODE/EXEC/MEM/WB) with one shared
// instruction/data memory port using a req/ready handshake. The register file
// and ALU are internal. Illegal opcodes, misaligned accesses and bus timeouts
// trap into HALT, which only reset leaves.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   mem_req/mem_we      access request (held until ready) and write strobe
//   mem_addr/mem_wdata  byte address and store data, stable while mem_req
//   mem_rdata/mem_ready read data and completion, sampled when mem_req
//   pc_out/alu_out      PC and ALUOut registers (debug)
//   d_mem_out           MDR register, last load data (debug)
//   state_out           0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 HALT
//   halted/trap_cause   HALT indicator and sticky trap cause
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 0
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc_out,
   output logic [31:0] alu_out,
   output logic [31:0] d_mem_out,
   output logic [2:0]  state_out,
   output logic        halted,
   output logic [1:0]  trap_cause
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] alu_reg;
   logic [31:0] mdr;
   logic [31:0] regs [32];
   logic [31:0] wait_cnt;
   logic [1:0]  trap;

   // Instruction fields
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [31:0] imm_s;
   logic [31:0] imm_z;

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign shamt = ir[10:6];
   assign funct = ir[5:0];
   assign imm   = ir[15:0];
   assign imm_s = {{16{imm[15]}}, imm};
   assign imm_z = {16'h0000, imm};

   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic        fetch_misaligned;
   logic        timeout_hit;
   logic        legal;
   logic [31:0] alu_res;

   assign rs_val        = (rs == 5'd0) ? 32'h0 : regs[rs];
   assign rt_val        = (rt == 5'd0) ? 32'h0 : regs[rt];
   assign jump_target   = {pc[31:28], ir[25:0], 2'b00};
   assign branch_target = pc + {imm_s[29:0], 2'b00};
   assign wb_dest       = (op == OP_RTYPE) ? rd : rt;
   assign wb_data       = (op == OP_LW)  ? mdr :
                          (op == OP_LUI) ? {imm, 16'h0000} : alu_reg;

   // A jr to a misaligned target traps in FETCH without issuing the request.
   assign fetch_misaligned = (pc[1:0] != 2'b00);
   // The wait that would reach the limit is the one that trips the trap.
   assign timeout_hit = (MEM_TIMEOUT != 0) &&
                        ((wait_cnt + 32'd1) == 32'(MEM_TIMEOUT));

   always_comb begin
      legal = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADD,
               FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
               default:                       legal = 1'b0;
            endcase
         end
         OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI,
         OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      alu_res = 32'h0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_res = a + b;
               FN_SUB:  alu_res = a - b;
               FN_AND:  alu_res = a & b;
               FN_OR:   alu_res = a | b;
               FN_SLT:  alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               FN_SLL:  alu_res = b << shamt;
               FN_SRL:  alu_res = b >> shamt;
               FN_SRA:  alu_res = 32'($signed(b) >>> shamt);
               default: alu_res = 32'h0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: alu_res = a + imm_s;
         OP_ANDI:               alu_res = a & imm_z;
         OP_ORI:                alu_res = a | imm_z;
         OP_SLTI:               alu_res = ($signed(a) < $signed(imm_s)) ? 32'd1 : 32'd0;
         OP_LUI:                alu_res = {imm, 16'h0000};
         OP_BEQ, OP_BNE:        alu_res = a - b;
         default:               alu_res = 32'h0;
      endcase
   end

   // Request is gated by reset so an in-flight transfer drops in the reset cycle.
   assign mem_req   = reset && ((state == S_FETCH && !fetch_misaligned) || state == S_MEM);
   assign mem_we    = (state == S_MEM) && (op == OP_SW);
   assign mem_addr  = (state == S_MEM) ? alu_reg : pc;
   assign mem_wdata = b;

   assign pc_out     = pc;
   assign alu_out    = alu_reg;
   assign d_mem_out  = mdr;
   assign state_out  = state;
   assign halted     = reset && (state == S_HALT);
   assign trap_cause = trap;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         ir       <= 32'h0;
         a        <= 32'h0;
         b        <= 32'h0;
         alu_reg  <= 32'h0;
         mdr      <= 32'h0;
         trap     <= 2'b00;
         wait_cnt <= 32'h0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      end else begin
         if (mem_req) begin
            if (mem_ready) wait_cnt <= 32'h0;
            else           wait_cnt <= wait_cnt + 32'd1;
         end

         case (state)
            S_FETCH: begin
               if (fetch_misaligned) begin
                  trap  <= 2'b10;
                  state <= S_HALT;
               end else if (mem_ready) begin
                  ir    <= mem_rdata;
                  pc    <= pc + 32'd4;
                  state <= S_DECODE;
               end else if (timeout_hit) begin
                  trap  <= 2'b11;
                  state <= S_HALT;
               end
            end

            S_DECODE: begin
               a <= rs_val;
               b <= rt_val;
               if (!legal) begin
                  trap  <= 2'b01;
                  state <= S_HALT;
               end else if (op == OP_J) begin
                  pc    <= jump_target;
                  state <= S_FETCH;
               end else if (op == OP_JAL) begin
                  // pc already holds the return address (PC+4)
                  regs[31] <= pc;
                  pc       <= jump_target;
                  state    <= S_FETCH;
               end else begin
                  state <= S_EXEC;
               end
            end

            S_EXEC: begin
               if ((op == OP_LW || op == OP_SW) && alu_res[1:0] != 2'b00) begin
                  trap  <= 2'b10;
                  state <= S_HALT;
               end else begin
                  alu_reg <= alu_res;
                  if (op == OP_BEQ || op == OP_BNE) begin
                     if ((a == b) == (op == OP_BEQ)) pc <= branch_target;
                     state <= S_FETCH;
                  end else if (op == OP_RTYPE && funct == FN_JR) begin
                     pc    <= a;
                     state <= S_FETCH;
                  end else if (op == OP_LW || op == OP_SW) begin
                     state <= S_MEM;
                  end else begin
                     state <= S_WB;
                  end
               end
            end

            S_MEM: begin
               if (mem_ready) begin
                  if (op == OP_SW) begin
                     state <= S_FETCH;
                  end else begin
                     mdr   <= mem_rdata;
                     state <= S_WB;
                  end
               end else if (timeout_hit) begin
                  trap  <= 2'b11;
                  state <= S_HALT;
               end
            end

            S_WB: begin
               if (wb_dest != 5'd0) regs[wb_dest] <= wb_data;
               state <= S_FETCH;
            end

            S_HALT: state <= S_HALT;

            default: state <= S_HALT;
         endcase
      end
   end

endmodule
